// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module : clk_div_pkg
// Brief  : Shared types and constants for the programmable clock divider.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

  // Default width of the divide-ratio field
  localparam int RATIO_W_DEFAULT = 4;

  // Smallest ratio that yields a real divided clock
  localparam int MIN_RATIO = 2;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // stopped, clk_q low, ratio may be written directly
    RUN  = 2'd1,  // producing clk_q
    PEND = 2'd2,  // producing clk_q, ratio change waiting for boundary
    STOP = 2'd3   // finishing the current period before going idle
  } state_t;

endpackage : clk_div_pkg

`default_nettype wire

// File: rtl/clk_div_core.sv
// ============================================================================
// Module : clk_div_core
// Brief  : Period counter and 50%-duty divided-clock generator. clk_q is
//          built only from flop outputs (posedge p, negedge n) so it stays
//          glitch-free; a new ratio is only ever seen at a period boundary.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_core #(
  parameter int RATIO_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,    // FSM next state is not IDLE
  input  logic [RATIO_W-1:0] ratio,  // ratio applied to the current period
  output logic [RATIO_W-1:0] cnt,
  output logic               bnd,    // last cycle of the current period
  output logic               clk_q
);

  logic               run_q;
  logic               p;
  logic               n;
  logic [RATIO_W-1:0] cnt_next;
  logic [RATIO_W:0]   half;
  logic               p_next;

  assign bnd  = run_q && (cnt == ratio - RATIO_W'(1));
  assign half = ({1'b0, ratio} + (RATIO_W + 1)'(1)) >> 1;

  // Look ahead one cycle so p can be a flop rather than a decoded compare.
  // At a boundary cnt_next is 0, so p_next does not depend on the ratio
  // that is about to change.
  always_comb begin
    cnt_next = '0;
    if (run && run_q && !bnd) begin
      cnt_next = cnt + RATIO_W'(1);
    end
    p_next = run && ({1'b0, cnt_next} < half);
  end

  // Posedge state: running flag, period counter and high-phase term p
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt   <= '0;
      p     <= 1'b0;
    end else begin
      run_q <= run;
      cnt   <= cnt_next;
      p     <= p_next;
    end
  end

  // Half-cycle delayed copy of p, used to trim odd ratios to 50% duty
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 1'b0;
    end else begin
      n <= p;
    end
  end

  // Odd ratios lose the first half-cycle of p; even ratios use p directly
  assign clk_q = ratio[0] ? (p & n) : p;

endmodule : clk_div_core

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// Module : clk_div_ctrl
// Brief  : Programmable clock divider with ratio-change handshake. Ratio
//          changes and stops are deferred to the period boundary so clk_q
//          never emits a partial period.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int RATIO_W     = RATIO_W_DEFAULT,
  parameter int RESET_RATIO = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               req_valid,
  input  logic [RATIO_W-1:0] req_ratio,
  output logic               req_ready,
  output logic               clk_q,
  output logic [RATIO_W-1:0] cur_ratio,
  output logic               period_start,
  output logic               busy,
  output logic               err
);

  state_t             state;
  state_t             state_next;
  logic [RATIO_W-1:0] pend_ratio;
  logic [RATIO_W-1:0] cnt;
  logic               bnd;
  logic               accept;
  logic               bad_ratio;

  assign req_ready    = (state == IDLE) || (state == RUN);
  assign busy         = (state != IDLE);
  assign period_start = busy && (cnt == '0);
  assign accept       = req_valid && req_ready;
  assign bad_ratio    = (req_ratio < RATIO_W'(MIN_RATIO));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a valid request in RUN takes priority over a stop
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = RUN;
      RUN: begin
        if (accept && !bad_ratio) begin
          state_next = PEND;
        end else if (!enable) begin
          state_next = STOP;
        end
      end
      PEND: if (bnd) state_next = enable ? RUN : IDLE;
      STOP: begin
        if (enable) begin
          state_next = RUN;
        end else if (bnd) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ratio registers and error pulse; rejected ratios change nothing else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ratio  <= RATIO_W'(RESET_RATIO);
      pend_ratio <= '0;
      err        <= 1'b0;
    end else begin
      err <= accept && bad_ratio;
      if (accept && !bad_ratio) begin
        if (state == IDLE) begin
          cur_ratio <= req_ratio;
        end else begin
          pend_ratio <= req_ratio;
        end
      end
      if ((state == PEND) && bnd) begin
        cur_ratio  <= pend_ratio;
        pend_ratio <= '0;
      end
    end
  end

  clk_div_core #(
    .RATIO_W (RATIO_W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_next != IDLE),
    .ratio (cur_ratio),
    .cnt   (cnt),
    .bnd   (bnd),
    .clk_q (clk_q)
  );

endmodule : clk_div_ctrl

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ============================================================================
// Module : tb_clk_div_ctrl
// Brief  : Directed self-checking bench for clk_div_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_ctrl;

  localparam int RATIO_W = 4;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic               req_valid;
  logic [RATIO_W-1:0] req_ratio;
  logic               req_ready;
  logic               clk_q;
  logic [RATIO_W-1:0] cur_ratio;
  logic               period_start;
  logic               busy;
  logic               err;

  int checks = 0;
  int errors = 0;
  int rises  = 0;

  clk_div_ctrl #(
    .RATIO_W     (RATIO_W),
    .RESET_RATIO (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_ratio    (req_ratio),
    .req_ready    (req_ready),
    .clk_q        (clk_q),
    .cur_ratio    (cur_ratio),
    .period_start (period_start),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every rising edge of clk_q, so a glitch shows up as an extra edge
  always @(posedge clk_q) rises++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 of a cnt==0 cycle; checks one full period at
  // posedge+1 and negedge+1 of every cycle plus exactly one clk_q rise.
  task automatic check_period(input string tag, input int n,
                              input logic [15:0] post, input logic [15:0] mid);
    int r0;
    r0 = rises;
    for (int c = 0; c < n; c++) begin
      chk({tag, "_post"}, 32'(clk_q), 32'(post[c]));
      chk({tag, "_pstart"}, 32'(period_start), 32'(c == 0));
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      #5;
      chk({tag, "_mid"}, 32'(clk_q), 32'(mid[c]));
      tick();
    end
    chk({tag, "_rises"}, 32'(rises - r0), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    req_valid = 1'b0;
    req_ratio = '0;

    // Reset values
    tick(); tick();
    chk("rst_clk_q", 32'(clk_q), 32'd0);
    chk("rst_ratio", 32'(cur_ratio), 32'd2);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_pstart", 32'(period_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Ratio 2: period 2, high 1
    enable = 1'b1;
    tick();
    chk("n2_busy", 32'(busy), 32'd1);
    check_period("n2a", 2, 16'b01, 16'b01);
    check_period("n2b", 2, 16'b01, 16'b01);
    // Stop at cnt 0 -> STOP for one cycle, IDLE after the boundary
    enable = 1'b0;
    tick();
    chk("stop2_busy", 32'(busy), 32'd1);
    chk("stop2_ready", 32'(req_ready), 32'd0);
    chk("stop2_clk_q", 32'(clk_q), 32'd0);
    tick();
    chk("idle2_busy", 32'(busy), 32'd0);
    chk("idle2_clk_q", 32'(clk_q), 32'd0);

    // IDLE ratio write to 3, then run: high 1.5 clk
    req_valid = 1'b1; req_ratio = 4'd3;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("idle_ratio3", 32'(cur_ratio), 32'd3);
    chk("idle_busy3", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();
    check_period("n3a", 3, 16'b010, 16'b011);
    check_period("n3b", 3, 16'b010, 16'b011);

    // Change to 4 through PEND
    req_valid = 1'b1; req_ratio = 4'd4;
    tick();
    req_valid = 1'b0;
    chk("p4_ready", 32'(req_ready), 32'd0);
    chk("p4_ratio_old", 32'(cur_ratio), 32'd3);
    tick();
    chk("p4_ready2", 32'(req_ready), 32'd0);
    tick();
    chk("n4_ratio", 32'(cur_ratio), 32'd4);
    chk("n4_ready", 32'(req_ready), 32'd1);
    chk("n4_pstart", 32'(period_start), 32'd1);
    chk("n4_c0", 32'(clk_q), 32'd1);
    tick();
    chk("n4_c1", 32'(clk_q), 32'd1);
    // Request 5 at cnt 1
    req_valid = 1'b1; req_ratio = 4'd5;
    tick();
    req_valid = 1'b0;
    chk("p5_ready", 32'(req_ready), 32'd0);
    chk("p5_ratio_old", 32'(cur_ratio), 32'd4);
    chk("p5_c2", 32'(clk_q), 32'd0);
    tick();
    chk("p5_c3", 32'(clk_q), 32'd0);
    chk("p5_ready2", 32'(req_ready), 32'd0);
    tick();
    chk("n5_ready", 32'(req_ready), 32'd1);
    chk("n5_ratio", 32'(cur_ratio), 32'd5);
    check_period("n5", 5, 16'b00110, 16'b00111);

    // Invalid ratios 1 and 0
    req_valid = 1'b1; req_ratio = 4'd1;
    tick();
    req_valid = 1'b0;
    chk("err1_pulse", 32'(err), 32'd1);
    chk("err1_ratio", 32'(cur_ratio), 32'd5);
    chk("err1_ready", 32'(req_ready), 32'd1);
    tick();
    chk("err1_clear", 32'(err), 32'd0);
    req_valid = 1'b1; req_ratio = 4'd0;
    tick();
    req_valid = 1'b0;
    chk("err0_pulse", 32'(err), 32'd1);
    chk("err0_ratio", 32'(cur_ratio), 32'd5);
    tick();
    chk("err0_clear", 32'(err), 32'd0);
    tick();
    chk("err_pstart", 32'(period_start), 32'd1);

    // Ratio 6, enable drop at cnt 2
    req_valid = 1'b1; req_ratio = 4'd6;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    chk("n6_ratio", 32'(cur_ratio), 32'd6);
    chk("n6_pstart", 32'(period_start), 32'd1);
    tick(); tick();
    chk("n6_c2", 32'(clk_q), 32'd1);
    enable = 1'b0;
    tick();
    chk("s6_c3_busy", 32'(busy), 32'd1);
    chk("s6_c3_ready", 32'(req_ready), 32'd0);
    chk("s6_c3_clk_q", 32'(clk_q), 32'd0);
    tick();
    chk("s6_c4_busy", 32'(busy), 32'd1);
    tick();
    chk("s6_c5_busy", 32'(busy), 32'd1);
    chk("s6_c5_pstart", 32'(period_start), 32'd0);
    tick();
    chk("s6_idle_busy", 32'(busy), 32'd0);
    chk("s6_idle_clk_q", 32'(clk_q), 32'd0);
    chk("s6_idle_pstart", 32'(period_start), 32'd0);
    tick();
    chk("s6_idle_clk_q2", 32'(clk_q), 32'd0);

    // PEND with enable low goes to IDLE at boundary with new ratio
    enable = 1'b1;
    tick();
    chk("f_busy", 32'(busy), 32'd1);
    chk("f_c0", 32'(clk_q), 32'd1);
    req_valid = 1'b1; req_ratio = 4'd3;
    tick();
    req_valid = 1'b0;
    enable = 1'b0;
    chk("f_ready", 32'(req_ready), 32'd0);
    repeat (4) tick();
    chk("f_c5_busy", 32'(busy), 32'd1);
    tick();
    chk("f_idle_busy", 32'(busy), 32'd0);
    chk("f_idle_ratio", 32'(cur_ratio), 32'd3);
    chk("f_idle_clk_q", 32'(clk_q), 32'd0);

    // Reset while clk_q high: immediate low, pending request lost
    enable = 1'b1;
    tick();
    chk("g_c0_post", 32'(clk_q), 32'd0);
    req_valid = 1'b1; req_ratio = 4'd5;
    tick();
    req_valid = 1'b0;
    #2;
    chk("g_high", 32'(clk_q), 32'd1);
    chk("g_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("g_rst_clk_q", 32'(clk_q), 32'd0);
    chk("g_rst_busy", 32'(busy), 32'd0);
    chk("g_rst_ratio", 32'(cur_ratio), 32'd2);
    chk("g_rst_ready", 32'(req_ready), 32'd1);
    enable = 1'b0;
    #3;
    rst_n = 1'b1;
    tick(); tick();
    chk("g_after_ratio", 32'(cur_ratio), 32'd2);
    chk("g_after_busy", 32'(busy), 32'd0);
    chk("g_after_clk_q", 32'(clk_q), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_clk_div_ctrl

`default_nettype wire
